// File: rtl/store_buffer_pkg.sv
// Shared constants and helpers for the store buffer: geometry defaults,
// enqueue decision encoding and the byte-lane merge function.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;
    localparam int SB_AW    = 30;
    localparam int SB_DW    = 32;
    localparam int SB_MW    = SB_DW / 8;

    typedef enum logic [1:0] {
        SB_OP_IDLE  = 2'd0,
        SB_OP_ALLOC = 2'd1,
        SB_OP_MERGE = 2'd2
    } sb_op_e;

    function automatic logic [SB_DW-1:0] merge_bytes(
        input logic [SB_DW-1:0] old_data,
        input logic [SB_DW-1:0] new_data,
        input logic [SB_MW-1:0] lane_mask
    );
        logic [SB_DW-1:0] res;
        res = old_data;
        for (int i = 0; i < SB_MW; i++) begin
            if (lane_mask[i]) res[8*i +: 8] = new_data[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-side, memory-side and load-probe signals of the store buffer.
// The buffer itself is the slave; the surrounding pipeline/memory is the master.
interface store_buffer_if #(
    parameter int AW = store_buffer_pkg::SB_AW
);
    logic                              enq_valid;
    logic                              enq_ready;
    logic [AW-1:0]                     enq_addr;
    logic [store_buffer_pkg::SB_DW-1:0] enq_data;
    logic [store_buffer_pkg::SB_MW-1:0] enq_mask;

    logic                              mem_valid;
    logic                              mem_ready;
    logic [AW-1:0]                     mem_addr;
    logic [store_buffer_pkg::SB_DW-1:0] mem_wdata;
    logic [store_buffer_pkg::SB_MW-1:0] mem_wmask;

    logic [AW-1:0]                     ld_addr;
    logic                              ld_valid;
    logic                              ld_hazard;

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_mask,
        output enq_ready,
        output mem_valid, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready,
        input  ld_addr, ld_valid,
        output ld_hazard
    );

    modport master (
        output enq_valid, enq_addr, enq_data, enq_mask,
        input  enq_ready,
        input  mem_valid, mem_addr, mem_wdata, mem_wmask,
        output mem_ready,
        output ld_addr, ld_valid,
        input  ld_hazard
    );

endinterface

// File: rtl/store_buffer_cam.sv
// N-way word-address comparator: one match bit per entry, gated by the
// entry's valid bit.
module store_buffer_cam #(
    parameter int N  = 4,
    parameter int AW = 30
) (
    input  logic [N-1:0][AW-1:0] entry_addr,
    input  logic [N-1:0]         entry_vld,
    input  logic [AW-1:0]        key,
    output logic [N-1:0]         match
);

    always_comb begin
        match = '0;
        for (int i = 0; i < N; i++) begin
            match[i] = entry_vld[i] && (entry_addr[i] == key);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order write queue between store formatting and the memory write port,
// with byte-merging into the youngest entry and a load-hazard probe.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = SB_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    store_buffer_if.slave          sb,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0]    addr_q,  addr_d;
    logic [DEPTH-1:0][SB_DW-1:0] data_q,  data_d;
    logic [DEPTH-1:0][SB_MW-1:0] mask_q,  mask_d;
    logic [PW-1:0]               head_q,  head_d;
    logic [PW-1:0]               tail_q,  tail_d;
    logic [CW-1:0]               count_q, count_d;

    logic [PW-1:0]    young;
    logic [DEPTH-1:0] young_sel;
    logic [DEPTH-1:0] ld_match;
    logic [DEPTH-1:0] young_match;
    logic             mem_vld;
    logic             enq_rdy;
    logic             deq;
    logic             merge_ok;
    logic             enq_fire;
    sb_op_e           enq_op;

    assign young     = tail_q - PW'(1);
    assign young_sel = DEPTH'(1) << young;

    store_buffer_cam #(.N(DEPTH), .AW(AW)) u_ld_cam (
        .entry_addr (addr_q),
        .entry_vld  (valid_q),
        .key        (sb.ld_addr),
        .match      (ld_match)
    );

    // Same comparator, restricted to the youngest slot for merge detection.
    store_buffer_cam #(.N(DEPTH), .AW(AW)) u_merge_cam (
        .entry_addr (addr_q),
        .entry_vld  (valid_q & young_sel),
        .key        (sb.enq_addr),
        .match      (young_match)
    );

    assign mem_vld  = (count_q != '0);
    assign deq      = mem_vld && sb.mem_ready;
    assign merge_ok = (count_q != '0) && (|young_match)
                      && !((count_q == CW'(1)) && deq);
    assign enq_rdy  = (count_q < CW'(DEPTH)) || merge_ok;
    assign enq_fire = sb.enq_valid && enq_rdy && (sb.enq_mask != '0);

    always_comb begin
        enq_op = SB_OP_IDLE;
        if (enq_fire) enq_op = merge_ok ? SB_OP_MERGE : SB_OP_ALLOC;
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        unique case (enq_op)
            SB_OP_ALLOC: begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = sb.enq_addr;
                data_d[tail_q]  = sb.enq_data;
                mask_d[tail_q]  = sb.enq_mask;
                tail_d          = tail_q + PW'(1);
            end
            SB_OP_MERGE: begin
                data_d[young] = merge_bytes(data_q[young], sb.enq_data, sb.enq_mask);
                mask_d[young] = mask_q[young] | sb.enq_mask;
            end
            default: ;
        endcase

        unique case ({enq_op == SB_OP_ALLOC, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign sb.enq_ready = enq_rdy;
    assign sb.mem_valid = mem_vld;
    assign sb.mem_addr  = addr_q[head_q];
    assign sb.mem_wdata = data_q[head_q];
    assign sb.mem_wmask = mask_q[head_q];
    assign sb.ld_hazard = sb.ld_valid && (|ld_match);
    assign empty        = (count_q == '0);
    assign count        = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and random stimulus for store_buffer, checked every cycle against
// a queue-based reference model of the pending stores.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = SB_DEPTH;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       empty;
    logic [2:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    ent_t mq[$];
    bit   fired_m;

    store_buffer_if sbi ();

    store_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbi.slave),
        .empty (empty),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_deq();
        return (mq.size() > 0) && sbi.mem_ready;
    endfunction

    function automatic bit m_merge();
        return (mq.size() > 0) && (mq[mq.size()-1].addr == sbi.enq_addr)
               && !(mq.size() == 1 && m_deq());
    endfunction

    function automatic bit m_ready();
        return (mq.size() < DEPTH) || m_merge();
    endfunction

    function automatic bit m_fire();
        return sbi.enq_valid && m_ready() && (sbi.enq_mask != 4'h0);
    endfunction

    function automatic bit m_hazard();
        if (!sbi.ld_valid) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == sbi.ld_addr) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_step();
        bit   d, mg, f;
        ent_t e;
        d  = m_deq();
        mg = m_merge();
        f  = m_fire();
        if (d) void'(mq.pop_front());
        if (f) begin
            if (mg) begin
                e = mq[mq.size()-1];
                for (int i = 0; i < 4; i++)
                    if (sbi.enq_mask[i]) e.data[8*i +: 8] = sbi.enq_data[8*i +: 8];
                e.mask = e.mask | sbi.enq_mask;
                mq[mq.size()-1] = e;
            end else begin
                e.addr = sbi.enq_addr;
                e.data = sbi.enq_data;
                e.mask = sbi.enq_mask;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_all();
        chk("enq_ready", 32'(sbi.enq_ready), 32'(m_ready()));
        chk("mem_valid", 32'(sbi.mem_valid), 32'(mq.size() > 0));
        chk("empty",     32'(empty),         32'(mq.size() == 0));
        chk("count",     32'(count),         32'(mq.size()));
        chk("ld_hazard", 32'(sbi.ld_hazard), 32'(m_hazard()));
        if (mq.size() > 0) begin
            chk("mem_addr",  32'(sbi.mem_addr),  32'(mq[0].addr));
            chk("mem_wdata", sbi.mem_wdata,      mq[0].data);
            chk("mem_wmask", 32'(sbi.mem_wmask), 32'(mq[0].mask));
        end
    endtask

    // Entered and left at posedge+1; outputs compared mid-cycle.
    task automatic cyc();
        #2;
        check_all();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic sync();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic set_enq(input logic v, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] m);
        sbi.enq_valid = v;
        sbi.enq_addr  = a;
        sbi.enq_data  = d;
        sbi.enq_mask  = m;
    endtask

    initial begin
        rst_n         = 1'b1;
        sbi.mem_ready = 1'b0;
        sbi.ld_valid  = 1'b0;
        sbi.ld_addr   = '0;
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);

        // reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_enq_ready", 32'(sbi.enq_ready), 32'd1);
        chk("rst_mem_valid", 32'(sbi.mem_valid), 32'd0);
        chk("rst_empty",     32'(empty),         32'd1);
        chk("rst_count",     32'(count),         32'd0);
        chk("rst_mem_addr",  32'(sbi.mem_addr),  32'd0);
        chk("rst_mem_wdata", sbi.mem_wdata,      32'd0);
        chk("rst_mem_wmask", 32'(sbi.mem_wmask), 32'd0);
        chk("rst_ld_hazard", 32'(sbi.ld_hazard), 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single drain
        sbi.mem_ready = 1'b1;
        set_enq(1'b1, 30'h100, 32'h0000_00AB, 4'b0001);
        cyc();
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        chk("drain_mem_valid", 32'(sbi.mem_valid), 32'd1);
        chk("drain_mem_addr",  32'(sbi.mem_addr),  32'h100);
        chk("drain_mem_wdata", sbi.mem_wdata,      32'h0000_00AB);
        chk("drain_mem_wmask", 32'(sbi.mem_wmask), 32'b0001);
        cyc();
        chk("drain_empty", 32'(empty), 32'd1);

        // merge
        sbi.mem_ready = 1'b0;
        set_enq(1'b1, 30'h40, 32'h0000_00AA, 4'b0001);
        cyc();
        set_enq(1'b1, 30'h40, 32'h00BB_0000, 4'b0100);
        cyc();
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        chk("merge_count", 32'(count),         32'd1);
        chk("merge_wdata", sbi.mem_wdata,      32'h00BB_00AA);
        chk("merge_wmask", 32'(sbi.mem_wmask), 32'b0101);
        sbi.mem_ready = 1'b1;
        cyc();
        cyc();

        // full / backpressure / wrap
        sbi.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_enq(1'b1, 30'(k), $urandom, 4'hF);
            cyc();
        end
        chk("full_count", 32'(count), 32'd4);
        set_enq(1'b1, 30'h9, 32'h1234_5678, 4'hF);
        #1 chk("full_ready_new", 32'(sbi.enq_ready), 32'd0);
        cyc();
        set_enq(1'b1, 30'h3, 32'h0000_5A00, 4'b0010);
        #1 chk("full_ready_merge", 32'(sbi.enq_ready), 32'd1);
        cyc();
        sbi.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_enq(1'b1, 30'h10 + 30'(k), $urandom, 4'hF);
            for (int t = 0; t < 8; t++) begin
                fired_m = m_fire();
                cyc();
                if (fired_m) break;
            end
        end
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        repeat (8) cyc();

        // concurrent enqueue/dequeue at count == 1 must not merge
        sbi.mem_ready = 1'b1;
        set_enq(1'b1, 30'h20, 32'h1122_3344, 4'hF);
        cyc();
        set_enq(1'b1, 30'h20, 32'h0000_CD00, 4'b0010);
        cyc();
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        chk("cc_count",     32'(count),         32'd1);
        chk("cc_mem_addr",  32'(sbi.mem_addr),  32'h20);
        chk("cc_mem_wmask", 32'(sbi.mem_wmask), 32'b0010);
        chk("cc_mem_wdata", sbi.mem_wdata,      32'h0000_CD00);
        cyc();

        // load hazard
        sbi.mem_ready = 1'b0;
        set_enq(1'b1, 30'h10, 32'hCAFE_0001, 4'hF);
        cyc();
        set_enq(1'b1, 30'h14, 32'hCAFE_0002, 4'hF);
        cyc();
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        sbi.ld_valid = 1'b1;
        sbi.ld_addr  = 30'h14;
        #1 chk("haz_hit", 32'(sbi.ld_hazard), 32'd1);
        sbi.ld_addr  = 30'h18;
        #1 chk("haz_miss", 32'(sbi.ld_hazard), 32'd0);
        sbi.ld_valid = 1'b0;
        sbi.ld_addr  = 30'h14;
        #1 chk("haz_novalid", 32'(sbi.ld_hazard), 32'd0);
        sync();

        // async reset mid-operation with three pending
        set_enq(1'b1, 30'h30, 32'hCAFE_0003, 4'hF);
        cyc();
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #2;
        chk("arst_mem_valid", 32'(sbi.mem_valid), 32'd0);
        chk("arst_count",     32'(count),         32'd0);
        chk("arst_empty",     32'(empty),         32'd1);
        mq.delete();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        sbi.mem_ready = 1'b1;
        repeat (3) cyc();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            sbi.mem_ready = ($urandom_range(0, 3) != 0);
            set_enq($urandom_range(0, 2) != 0, 30'h40 + 30'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)));
            sbi.ld_valid = $urandom_range(0, 1) != 0;
            sbi.ld_addr  = 30'h40 + 30'($urandom_range(0, 5));
            cyc();
        end
        set_enq(1'b0, 30'h0, 32'h0, 4'h0);
        sbi.mem_ready = 1'b1;
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
